// File: rtl/object_placement_sequencer.sv
// Places up to MAX_OBJ level objects on free, distinct grid cells using the shared random source.
// Latency: start@T -> first DRAW at T+1; each accepted placement costs 3 cycles, obj_wr 2 cycles after the accepting DRAW.
// Backpressure: none; a rejected draw costs one cycle, a solid wall two; MAX_TRIES rejects per object abort the sequence.
//
// Ports:
//   clk, resetN                       - clock, asynchronous active-low reset
//   start, level_select               - level-start pulse (IDLE only) and level number (N = 2 + level)
//   random_num1/2                     - per-cycle random column/row candidates
//   wall_rd_req/col/row, wall_is_solid- wall-map read port; response arrives one cycle after the request
//   obj_wr, obj_idx, obj_topLeftX/Y   - one-cycle placement strobe with object index and pixel position
//   busy, done, fail                  - sequence status; fail is qualified by done
module object_placement_sequencer #(
    parameter int GRID_COLS = 9,
    parameter int GRID_ROWS = 6,
    parameter int X_OFFSET  = 15,
    parameter int Y_OFFSET  = 48,
    parameter int MAX_OBJ   = 5,
    parameter int MAX_TRIES = 255
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        start,
    input  logic [1:0]  level_select,
    input  logic [4:0]  random_num1,
    input  logic [4:0]  random_num2,
    output logic        wall_rd_req,
    output logic [3:0]  wall_rd_col,
    output logic [3:0]  wall_rd_row,
    input  logic        wall_is_solid,
    output logic        obj_wr,
    output logic [2:0]  obj_idx,
    output logic [10:0] obj_topLeftX,
    output logic [10:0] obj_topLeftY,
    output logic        busy,
    output logic        done,
    output logic        fail
);

    localparam int              TW           = $clog2(MAX_TRIES + 1);
    localparam logic [4:0]      LP_COLS      = 5'(GRID_COLS);
    localparam logic [4:0]      LP_ROWS      = 5'(GRID_ROWS);
    localparam logic [10:0]     LP_XOFF      = 11'(X_OFFSET);
    localparam logic [10:0]     LP_YOFF      = 11'(Y_OFFSET);
    localparam logic [TW-1:0]   LP_MAX_TRIES = TW'(MAX_TRIES);

    typedef enum logic [2:0] {S_IDLE, S_DRAW, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [2:0]      r_n, r_idx;
    logic [TW-1:0]   r_tries;
    logic [3:0]      r_col, r_row;
    logic [3:0]      r_tab_col [MAX_OBJ];
    logic [3:0]      r_tab_row [MAX_OBJ];
    logic [MAX_OBJ-1:0] r_tab_vld;
    logic            r_obj_wr, r_busy, r_done, r_fail;
    logic [2:0]      r_obj_idx;
    logic [10:0]     r_px_x, r_px_y;

    logic            w_in_range, w_spawn, w_dup, w_accept, w_fail_next;
    logic [TW-1:0]   w_tries_inc;
    logic [10:0]     w_px_x, w_px_y;

    always_comb begin
        w_in_range  = (random_num1 < LP_COLS) && (random_num2 < LP_ROWS);
        w_spawn     = (random_num1 == 5'd0 && random_num2 == 5'd0) ||
                      (random_num1 == 5'd1 && random_num2 == 5'd0) ||
                      (random_num1 == 5'd0 && random_num2 == 5'd1);
        // Only slots placed in the current sequence take part in the duplicate check.
        w_dup = 1'b0;
        for (int i = 0; i < MAX_OBJ; i++) begin
            if (r_tab_vld[i] && ({1'b0, r_tab_col[i]} == random_num1) &&
                ({1'b0, r_tab_row[i]} == random_num2)) begin
                w_dup = 1'b1;
            end
        end
        w_accept    = w_in_range && !w_spawn && !w_dup;
        w_tries_inc = r_tries + TW'(1);
        w_px_x      = ({7'd0, r_col} << 6) + LP_XOFF;
        w_px_y      = ({7'd0, r_row} << 6) + LP_YOFF;

        w_next      = r_state;
        w_fail_next = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_next = S_DRAW;
            S_DRAW: begin
                if (w_accept) begin
                    w_next = S_WAIT;
                end else if (w_tries_inc == LP_MAX_TRIES) begin
                    w_next      = S_DONE;
                    w_fail_next = 1'b1;
                end
            end
            S_WAIT: begin
                if (!wall_is_solid) begin
                    w_next = S_WRITE;
                end else if (w_tries_inc == LP_MAX_TRIES) begin
                    w_next      = S_DONE;
                    w_fail_next = 1'b1;
                end else begin
                    w_next = S_DRAW;
                end
            end
            S_WRITE: w_next = ((r_idx + 3'd1) == r_n) ? S_DONE : S_DRAW;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_n       <= 3'd0;
            r_idx     <= 3'd0;
            r_tries   <= '0;
            r_col     <= 4'd0;
            r_row     <= 4'd0;
            r_tab_vld <= '0;
            for (int i = 0; i < MAX_OBJ; i++) begin
                r_tab_col[i] <= 4'd0;
                r_tab_row[i] <= 4'd0;
            end
            r_obj_wr  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_fail    <= 1'b0;
            r_obj_idx <= 3'd0;
            r_px_x    <= 11'd0;
            r_px_y    <= 11'd0;
        end else begin
            // Status strobes are registered from the next state so they line up with that state's cycle.
            r_obj_wr <= (w_next == S_WRITE);
            r_done   <= (w_next == S_DONE);
            r_fail   <= w_fail_next;
            r_busy   <= (w_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n       <= 3'd2 + {1'b0, level_select};
                        r_tab_vld <= '0;
                        r_idx     <= 3'd0;
                        r_tries   <= '0;
                    end
                end
                S_DRAW: begin
                    if (w_accept) begin
                        r_col <= random_num1[3:0];
                        r_row <= random_num2[3:0];
                    end else begin
                        r_tries <= w_tries_inc;
                    end
                end
                S_WAIT: begin
                    if (wall_is_solid) begin
                        r_tries <= w_tries_inc;
                    end else begin
                        r_obj_idx <= r_idx;
                        r_px_x    <= w_px_x;
                        r_px_y    <= w_px_y;
                    end
                end
                S_WRITE: begin
                    r_tab_col[r_idx] <= r_col;
                    r_tab_row[r_idx] <= r_row;
                    r_tab_vld[r_idx] <= 1'b1;
                    r_idx            <= r_idx + 3'd1;
                    r_tries          <= '0;
                end
                default: ;
            endcase
        end
    end

    // The read request is issued in the accepting DRAW cycle so the response lands in WAIT;
    // the address is then held from the latched candidate.
    assign wall_rd_req  = (r_state == S_DRAW) && w_accept;
    assign wall_rd_col  = (r_state == S_DRAW) ? random_num1[3:0] : r_col;
    assign wall_rd_row  = (r_state == S_DRAW) ? random_num2[3:0] : r_row;
    assign obj_wr       = r_obj_wr;
    assign obj_idx      = r_obj_idx;
    assign obj_topLeftX = r_px_x;
    assign obj_topLeftY = r_px_y;
    assign busy         = r_busy;
    assign done         = r_done;
    assign fail         = r_fail;

endmodule

// File: doc/object_placement_sequencer.md
# object_placement_sequencer

Sequences the shared random-number source to place up to MAX_OBJ level objects (door, idol, pickups) on free, distinct grid cells at the start of each level. It sits between the random generator, the wall/brick map read port and the object registers. Each accepted placement is issued as a one-cycle write carrying the object index and its top-left pixel coordinates.

## Interface
- GRID_COLS, 9: valid column range 0..GRID_COLS-1
- GRID_ROWS, 6: valid row range 0..GRID_ROWS-1
- X_OFFSET, 15: pixel X of column 0
- Y_OFFSET, 48: pixel Y of row 0
- MAX_OBJ, 5: object slots; must be ≥ 2+3
- MAX_TRIES, 255: rejected draws allowed per object before failure

- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- start  in  1  level-start pulse; ignored unless in IDLE
- level_select  in  2  level number; latched on accepted start
- random_num1  in  5  random column candidate, new value every cycle
- random_num2  in  5  random row candidate, new value every cycle
- wall_rd_req  out  1  one-cycle wall-map read request
- wall_rd_col  out  4  queried column, held from request until the response cycle
- wall_rd_row  out  4  queried row, held from request until the response cycle
- wall_is_solid  in  1  wall-map response, valid exactly one cycle after wall_rd_req
- obj_wr  out  1  one-cycle placement strobe
- obj_idx  out  3  object index, valid with obj_wr
- obj_topLeftX  out  11  pixel X = col*64 + X_OFFSET, valid with obj_wr
- obj_topLeftY  out  11  pixel Y = row*64 + Y_OFFSET, valid with obj_wr
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the sequence ends
- fail  out  1  valid with done; 1 if the sequence aborted

## Operation
- Object count: N = 2 + level_select, latched at start. Index 0 is the door; index 1 is the idol.
- States:
  - IDLE: on start, latch N, clear the placed-cell table, set idx=0 and tries=0, go to DRAW.
  - DRAW: sample random_num1/random_num2 as col/row. Reject the draw if any of these hold:
    - col ≥ GRID_COLS or row ≥ GRID_ROWS
    - the cell is a spawn cell (0,0), (1,0) or (0,1)
    - the cell equals any cell already placed in this sequence
  - DRAW on reject: tries++ and stay in DRAW.
  - DRAW on accept: drive wall_rd_req=1 with col/row, go to WAIT.
  - WAIT: sample wall_is_solid.
    - Solid: tries++, go to DRAW.
    - Not solid: go to WRITE.
  - WRITE: pulse obj_wr with idx and coordinates, store the cell in table[idx], idx++, tries=0. If idx+1 == N, go to DONE; otherwise go to DRAW.
  - DONE: pulse done with fail=0, go to IDLE.
- Failure: when tries reaches MAX_TRIES on a reject, pulse done with fail=1 in the next cycle and go to IDLE. Objects already written remain valid; no further obj_wr is issued.
- Arithmetic: col and row are zero-extended to 11 bits before the shift-by-6 and offset add. No overflow is possible with the default parameters (max X 527, max Y 368).
- start during busy: ignored; N and the table are unchanged.

## Timing
- Reset values: wall_rd_req=0, wall_rd_col=0, wall_rd_row=0, obj_wr=0, obj_idx=0, obj_topLeftX=0, obj_topLeftY=0, busy=0, done=0, fail=0. State is IDLE and the table is cleared.
- Reset mid-sequence: returns to IDLE immediately. No obj_wr or done is issued for the aborted sequence.
- Cycle costs:
  - start at cycle T puts DRAW at T+1.
  - Accepted attempt: 3 cycles (DRAW → WAIT → WRITE). obj_wr is asserted 2 cycles after the accepting DRAW.
  - Rejected draw: 1 cycle. Wall rejection: 2 cycles.
- Minimum sequence for N=2 with no rejects: start@T, obj_wr@T+3 and T+6, done@T+7, busy falls at T+8.
- Outputs are registered. obj_topLeftX/Y and obj_idx hold their last value between strobes.
- A start that coincides with the done cycle is ignored; a new start is accepted only from IDLE.

## Test plan
- Reset then start, level_select=0, with no walls, randoms (3,2) then (4,1):
  - obj_wr idx0 at X=207, Y=176
  - obj_wr idx1 at X=271, Y=112
  - done=1, fail=0 at T+7
- Randoms (20,2), (0,0), (3,2), (3,2), (5,5), level 0:
  - out-of-range, spawn and duplicate draws are rejected
  - placements are (3,2) and (5,5); exactly 2 obj_wr pulses
- wall_is_solid=1 for cell (3,2), randoms (3,2), (6,3), (7,4):
  - door at X=399, Y=240
  - idol at X=463, Y=304
  - no obj_wr for (3,2)
- Randoms held at (0,0), level 3:
  - done=1, fail=1 after 255 rejects (start@T → done@T+256)
  - zero obj_wr pulses
- level_select=3 with valid distinct randoms: 5 obj_wr pulses, idx 0..4 in order. A start pulsed mid-sequence changes nothing.
- resetN low between the 1st and 2nd obj_wr:
  - all outputs return to 0 and busy=0
  - a following start produces a complete fresh sequence beginning at idx0
